// File: rtl/act_pkg.sv
// act_pkg: activation mode codes and a shared popcount helper
package act_pkg;

    localparam logic [1:0] ACT_RELU   = 2'b00;
    localparam logic [1:0] ACT_STEP   = 2'b01;
    localparam logic [1:0] ACT_SCLAMP = 2'b10;

    function automatic int popcount(input logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) n = n + 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/act_func_pipe_if.sv
// act_func_pipe_if: input/output handshake, data and counter-control bundle of the activation unit
interface act_func_pipe_if #(
    parameter int CH    = 4,
    parameter int IN_W  = 12,
    parameter int OUT_W = 5,
    parameter int CNT_W = 16
) ();
    logic [1:0]          mode;
    logic                in_valid;
    logic                in_ready;
    logic [CH*IN_W-1:0]  in_data;
    logic                out_valid;
    logic                out_ready;
    logic [CH*OUT_W-1:0] out_data;
    logic [CH-1:0]       out_sat;
    logic                clr_cnt;
    logic [CNT_W-1:0]    sat_count;

    modport master (
        output mode, in_valid, in_data, out_ready, clr_cnt,
        input  in_ready, out_valid, out_data, out_sat, sat_count
    );

    modport slave (
        input  mode, in_valid, in_data, out_ready, clr_cnt,
        output in_ready, out_valid, out_data, out_sat, sat_count
    );
endinterface

// File: rtl/act_lane.sv
// act_lane: one lane; front half shifts the raw sum, back half applies the mode and clamps
module act_lane
    import act_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int OUT_W = 5,
    parameter int SHIFT = 5,
    localparam int S_W  = IN_W - SHIFT
) (
    input  logic [IN_W-1:0]  i_x,
    output logic [S_W-1:0]   o_s,
    output logic             o_pos,
    input  logic [S_W-1:0]   i_s,
    input  logic             i_pos,
    input  logic [1:0]       i_mode,
    output logic [OUT_W-1:0] o_y,
    output logic             o_sat
);
    localparam int UMAX = 2**OUT_W - 1;
    localparam int SMAX = 2**(OUT_W-1) - 1;
    localparam int SMIN = -(2**(OUT_W-1));

    logic signed [31:0] w_v;
    logic signed [31:0] w_c;
    logic               w_uhi;
    logic               w_neg;
    logic               w_shi;
    logic               w_slo;

    // Dropping the low bits of a two's complement value is a floor shift; STEP needs the
    // sign of the unshifted value, so it travels alongside as a single flag.
    assign o_s   = i_x[IN_W-1:SHIFT];
    assign o_pos = !i_x[IN_W-1] && |i_x;

    assign w_v   = {{(32-S_W){i_s[S_W-1]}}, i_s};
    assign w_uhi = w_v > UMAX;
    assign w_neg = w_v < 0;
    assign w_shi = w_v > SMAX;
    assign w_slo = w_v < SMIN;

    // Mode mux with clamping; code 2'b11 falls through to RELU
    always_comb begin
        w_c   = (i_mode == ACT_STEP)   ? 32'(i_pos) :
                (i_mode == ACT_SCLAMP) ? (w_slo ? SMIN : w_shi ? SMAX : w_v) :
                                         (w_neg ? 0 : w_uhi ? UMAX : w_v);
        o_sat = (i_mode == ACT_STEP)   ? 1'b0 :
                (i_mode == ACT_SCLAMP) ? (w_slo || w_shi) : w_uhi;
        o_y   = w_c[OUT_W-1:0];
    end
endmodule

// File: rtl/act_func_pipe.sv
// act_func_pipe: two-stage CH-lane activation pipeline with valid/ready handshake and saturation counter
module act_func_pipe
    import act_pkg::*;
#(
    parameter int CH    = 4,
    parameter int IN_W  = 12,
    parameter int OUT_W = 5,
    parameter int SHIFT = 5,
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    act_func_pipe_if.slave  bus
);
    localparam int S_W = IN_W - SHIFT;

    logic                r_s1_v;
    logic [CH*S_W-1:0]   r_s1_s;
    logic [CH-1:0]       r_s1_pos;
    logic [1:0]          r_s1_mode;
    logic                r_s2_v;
    logic [CH*OUT_W-1:0] r_s2_y;
    logic [CH-1:0]       r_s2_sat;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_s2_adv;
    logic                w_s1_adv;
    logic                w_hs;
    logic [CH*S_W-1:0]   w_s;
    logic [CH-1:0]       w_pos;
    logic [CH*OUT_W-1:0] w_y;
    logic [CH-1:0]       w_sat;
    logic [CNT_W:0]      w_sum;
    logic [CNT_W-1:0]    w_cnt_nxt;

    // A stage may load when it is empty or its contents move on this cycle
    assign w_s2_adv = !r_s2_v || bus.out_ready;
    assign w_s1_adv = !r_s1_v || w_s2_adv;
    assign w_hs     = r_s2_v && bus.out_ready;

    for (genvar g = 0; g < CH; g++) begin : g_lane
        act_lane #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_lane (
            .i_x    (bus.in_data[g*IN_W +: IN_W]),
            .o_s    (w_s[g*S_W +: S_W]),
            .o_pos  (w_pos[g]),
            .i_s    (r_s1_s[g*S_W +: S_W]),
            .i_pos  (r_s1_pos[g]),
            .i_mode (r_s1_mode),
            .o_y    (w_y[g*OUT_W +: OUT_W]),
            .o_sat  (w_sat[g])
        );
    end

    // Stage 1: capture shifted lanes and the beat's mode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_s    <= '0;
            r_s1_pos  <= '0;
            r_s1_mode <= ACT_RELU;
        end else if (w_s1_adv) begin
            r_s1_v    <= bus.in_valid;
            r_s1_s    <= w_s;
            r_s1_pos  <= w_pos;
            r_s1_mode <= bus.mode;
        end
    end

    // Stage 2: capture activated lanes; held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_v   <= 1'b0;
            r_s2_y   <= '0;
            r_s2_sat <= '0;
        end else if (w_s2_adv) begin
            r_s2_v   <= r_s1_v;
            r_s2_y   <= w_y;
            r_s2_sat <= w_sat;
        end
    end

    // Saturating add of flagged lanes per output handshake; clear takes priority
    always_comb begin
        w_sum     = {1'b0, r_cnt} + (CNT_W+1)'(popcount({{(64-CH){1'b0}}, r_s2_sat}));
        w_cnt_nxt = bus.clr_cnt ? '0 : !w_hs ? r_cnt : w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end

    // Saturation counter register
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= w_cnt_nxt;
    end

    assign bus.in_ready  = w_s1_adv;
    assign bus.out_valid = r_s2_v;
    assign bus.out_data  = r_s2_y;
    assign bus.out_sat   = r_s2_sat;
    assign bus.sat_count = r_cnt;
endmodule

// File: tb/tb_act_func_pipe.sv
// tb_act_func_pipe: randomized and directed scoreboard bench for act_func_pipe
module tb_act_func_pipe;
    localparam int CH = 4, IN_W = 12, OUT_W = 5, SHIFT = 5, CNT_W = 16;
    localparam int CMAX = 2**CNT_W - 1;

    typedef struct packed {
        logic [CH*OUT_W-1:0] y;
        logic [CH-1:0]       sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rand_rdy = 1'b0;
    logic rdy_force = 1'b1;
    logic saw_stall = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   m_cnt = 0;
    exp_t q[$];

    act_func_pipe_if #(.CH(CH), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    act_func_pipe #(.CH(CH), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic exp_t model(input logic [1:0] m, input logic [CH*IN_W-1:0] d);
        exp_t r;
        int x, s, v, dv;
        logic [31:0] vb;
        dv = 2**SHIFT;
        for (int k = 0; k < CH; k++) begin
            x = int'(d[k*IN_W +: IN_W]);
            if (x >= 2**(IN_W-1)) x = x - 2**IN_W;
            s = (x >= 0) ? x / dv : -((-x + dv - 1) / dv);
            r.sat[k] = 1'b0;
            if (m == 2'b01) v = (x > 0) ? 1 : 0;
            else if (m == 2'b10) begin
                v = (s < -(2**(OUT_W-1))) ? -(2**(OUT_W-1)) : (s > 2**(OUT_W-1)-1) ? 2**(OUT_W-1)-1 : s;
                r.sat[k] = (v != s);
            end else begin
                v = (s < 0) ? 0 : (s > 2**OUT_W-1) ? 2**OUT_W-1 : s;
                r.sat[k] = (s > 2**OUT_W-1);
            end
            vb = v;
            r.y[k*OUT_W +: OUT_W] = vb[OUT_W-1:0];
        end
        return r;
    endfunction

    function automatic logic [CH*IN_W-1:0] pack4(input logic [IN_W-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Downstream ready: random or forced by the main sequence
    always @(posedge clk) begin
        #1 bus.out_ready = rand_rdy ? ($urandom_range(3) != 0) : rdy_force;
    end

    // Monitor and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            chk("sat_count", 64'(bus.sat_count), 64'(m_cnt));
            if (bus.in_valid && !bus.in_ready) saw_stall = 1'b1;
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.mode, bus.in_data));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_beat: got data %0h with no beat outstanding", bus.out_data);
                end else begin
                    chk("out_data", 64'(bus.out_data), 64'(q[0].y));
                    chk("out_sat", 64'(bus.out_sat), 64'(q[0].sat));
                end
            end
            if (bus.clr_cnt) m_cnt = 0;
            else if (bus.out_valid && bus.out_ready && q.size() != 0) begin
                m_cnt = m_cnt + $countones(q[0].sat);
                if (m_cnt > CMAX) m_cnt = CMAX;
            end
            if (bus.out_valid && bus.out_ready && q.size() != 0) void'(q.pop_front());
        end
    end

    task automatic send(input logic [1:0] m, input logic [CH*IN_W-1:0] d);
        logic acc;
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.in_data  = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, required 1");
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            if (q.size() == 0 && !bus.out_valid) return;
            @(posedge clk);
            #1;
        end
        n_chk++;
        n_fail++;
        $display("FAIL drain_timeout: %0d beats still outstanding, required 0", q.size());
    endtask

    task automatic directed(input logic [1:0] m, input logic [CH*IN_W-1:0] d, input logic [CH*OUT_W-1:0] ey);
        send(m, d);
        chk("latency_early", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("latency_valid", 64'(bus.out_valid), 64'd1);
        chk("directed_data", 64'(bus.out_data), 64'(ey));
        drain();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.mode     = 2'b00;
        bus.in_data  = '0;
        bus.clr_cnt  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_sat", 64'(bus.out_sat), 64'd0);
        chk("rst_sat_count", 64'(bus.sat_count), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;

        directed(2'b00, pack4(12'h333, 12'hCCC, 12'h7FF, 12'h000), {5'd0, 5'd31, 5'd0, 5'd25});
        chk("relu_sat_count", 64'(bus.sat_count), 64'd1);
        directed(2'b10, pack4(12'hCCC, 12'h800, 12'h1E0, 12'hFE0), {5'h1F, 5'h0F, 5'h10, 5'h10});
        directed(2'b01, pack4(12'h001, 12'h000, 12'hFFF, 12'h333), {5'd1, 5'd0, 5'd0, 5'd1});
        directed(2'b11, pack4(12'h7FF, 12'h020, 12'hFFF, 12'h3E0), {5'd31, 5'd0, 5'd1, 5'd31});

        saw_stall = 1'b0;
        fork
            for (int i = 0; i < 6; i++) send(2'(i % 3), {24'($urandom), 24'($urandom)});
            begin
                repeat (2) @(posedge clk);
                #1 rdy_force = 1'b0;
                repeat (3) @(posedge clk);
                #1 rdy_force = 1'b1;
            end
        join
        drain();
        chk("backpressure_stall", 64'(saw_stall), 64'd1);

        fork
            for (int i = 0; i < 20; i++) send(2'b00, {CH{12'h7FF}});
            begin
                repeat (8) @(posedge clk);
                #1 bus.clr_cnt = 1'b1;
                @(negedge clk);
                chk("clr_with_handshake", 64'(bus.out_valid && bus.out_ready), 64'd1);
                @(posedge clk);
                #1 bus.clr_cnt = 1'b0;
                @(negedge clk);
                chk("clr_wins", 64'(bus.sat_count), 64'd0);
            end
        join
        drain();

        for (int i = 0; i < 16400; i++) send(2'b10, {CH{12'h800}});
        drain();
        chk("cnt_saturated", 64'(bus.sat_count), 64'(CMAX));
        send(2'b00, {CH{12'h7FF}});
        drain();
        chk("cnt_no_wrap", 64'(bus.sat_count), 64'(CMAX));

        rdy_force = 1'b0;
        send(2'b00, pack4(12'h100, 12'h200, 12'h300, 12'h7FF));
        send(2'b10, pack4(12'h100, 12'h200, 12'h300, 12'h7FF));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_force = 1'b1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst_sat_count", 64'(bus.sat_count), 64'd0);
        directed(2'b00, pack4(12'h040, 12'h000, 12'h000, 12'h000), {5'd0, 5'd0, 5'd0, 5'd2});

        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(2)) @(posedge clk);
            #0;
            send(2'($urandom), {16'($urandom), 32'($urandom)});
        end
        rand_rdy = 1'b0;
        rdy_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
